// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code source: FSM states, direction codes and
// a width-generic binary-to-Gray helper.
package gray_pkg;

  localparam int unsigned FN_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Callers zero-extend into FN_W bits and truncate the result back.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
//   bin    : binary input
//   gray_c : Gray-coded output, bin ^ (bin >> 1)
module gray_encode
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  assign gray_c = WIDTH'(bin2gray(FN_W'(bin)));

endmodule

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source. Emits a programmed number of Gray codes, counting
// up or down modulo 2^WIDTH, one per valid/ready transfer.
//   clk, rst_n          : clock, async active-low reset
//   load_en, load_bin   : load binary counter (IDLE only)
//   start, up_dn, step_cnt : begin a run (IDLE only), direction and beat count
//   stop                : abort the current run without a done pulse
//   ready               : downstream accepts G_out this cycle
//   G_out, valid        : registered Gray code and its qualifier
//   busy, done          : run in progress / one-cycle completion pulse
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             start,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] step_cnt,
  input  logic             stop,
  input  logic             ready,
  output logic [WIDTH-1:0] G_out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic             dir_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] bin_eff_c;
  logic [WIDTH-1:0] bin_step_c;
  logic [WIDTH-1:0] bin_sel_c;
  logic [WIDTH-1:0] gray_c;

  // A load coinciding with start takes effect first, so the run opens on load_bin.
  assign bin_eff_c  = load_en ? load_bin : bin_q;
  assign bin_step_c = (dir_q == DIR_UP) ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
  // In IDLE the encoder prepares the first code; in RUN it prepares the next one.
  assign bin_sel_c  = (state_q == ST_IDLE) ? bin_eff_c : bin_step_c;

  gray_encode #(.WIDTH(WIDTH)) u_enc (
    .bin    (bin_sel_c),
    .gray_c (gray_c)
  );

  // Run sequencer with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      bin_q   <= '0;
      rem_q   <= '0;
      G_out   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done <= 1'b0;
          if (load_en) bin_q <= load_bin;
          if (start) begin
            if (step_cnt != '0) begin
              state_q <= ST_RUN;
              dir_q   <= up_dn;
              rem_q   <= step_cnt;
              G_out   <= gray_c;
              valid   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // valid is always high here, so ready alone marks a transfer.
          if (ready) begin
            bin_q <= bin_step_c;
            G_out <= gray_c;
            rem_q <= rem_q - WIDTH'(1);
          end
          if (stop) begin
            state_q <= ST_IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
          end else if (ready && rem_q == WIDTH'(1)) begin
            state_q <= ST_DONE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_seq_gen.sv
module tb_gray_seq_gen;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_en;
  logic [W-1:0] load_bin;
  logic         start;
  logic         up_dn;
  logic [W-1:0] step_cnt;
  logic         stop;
  logic         ready;
  logic [W-1:0] G_out;
  logic         valid;
  logic         busy;
  logic         done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] ref_bin;
  logic [W-1:0] prev_g;
  int           xfers;

  gray_seq_gen #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .load_bin (load_bin),
    .start    (start),
    .up_dn    (up_dn),
    .step_cnt (step_cnt),
    .stop     (stop),
    .ready    (ready),
    .G_out    (G_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]        load;
    logic                up;
    logic [W-1:0]        step;
    logic [9:0][W-1:0]   exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Called with outputs stable before an edge; if a transfer will occur, check
  // the code against the reference counter and advance it.
  task automatic beat_model(input logic dir);
    if (valid && ready) begin
      check("ref_bin", 32'(g2b(G_out)), 32'(ref_bin));
      if (xfers > 0) check("hamming1", 32'($countones(G_out ^ prev_g)), 32'd1);
      prev_g = G_out;
      xfers++;
      ref_bin = dir ? ref_bin + W'(1) : ref_bin - W'(1);
    end
  endtask

  task automatic begin_run(input logic ld, input logic [W-1:0] lv, input logic dir,
                           input logic [W-1:0] n);
    load_en  = ld;
    load_bin = lv;
    start    = 1'b1;
    up_dn    = dir;
    step_cnt = n;
    if (ld) ref_bin = lv;
    xfers = 0;
    step_edge();
    load_en = 1'b0;
    start   = 1'b0;
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{load: 8'h00, up: 1'b1, step: 8'd10,
                exp: {8'h0D, 8'h0C, 8'h04, 8'h05, 8'h07, 8'h06, 8'h02, 8'h03, 8'h01, 8'h00}};
    vecs[1] = '{load: 8'hFE, up: 1'b1, step: 8'd3,
                exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h81}};
    vecs[2] = '{load: 8'h01, up: 1'b0, step: 8'd3,
                exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h01}};
    vecs[3] = '{load: 8'h7F, up: 1'b1, step: 8'd2,
                exp: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h40}};

    rst_n = 1'b0; load_en = 1'b0; load_bin = '0; start = 1'b0; up_dn = 1'b1;
    step_cnt = '0; stop = 1'b0; ready = 1'b0; ref_bin = '0; prev_g = '0; xfers = 0;
    #12;
    check("rst_G_out", 32'(G_out), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_done",  32'(done),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step_edge();

    // Reset asserted mid-run must clear outputs with no clock edge.
    ready = 1'b1;
    begin_run(1'b1, 8'h20, 1'b1, 8'd10);
    step_edge();
    step_edge();
    check("mid_run_valid", 32'(valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_G_out", 32'(G_out), 32'h0);
    check("async_valid", 32'(valid), 32'h0);
    check("async_busy",  32'(busy),  32'h0);
    check("async_done",  32'(done),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step_edge();

    // Table of full runs with ready held high.
    for (int v = 0; v < 4; v++) begin
      ready = 1'b1;
      begin_run(1'b1, vecs[v].load, vecs[v].up, vecs[v].step);
      for (int i = 0; i < int'(vecs[v].step); i++) begin
        check($sformatf("v%0d_valid%0d", v, i), 32'(valid), 32'h1);
        check($sformatf("v%0d_busy%0d", v, i), 32'(busy), 32'h1);
        check($sformatf("v%0d_code%0d", v, i), 32'(G_out), 32'(vecs[v].exp[i]));
        check($sformatf("v%0d_nodone%0d", v, i), 32'(done), 32'h0);
        beat_model(vecs[v].up);
        step_edge();
      end
      check($sformatf("v%0d_done", v), 32'(done), 32'h1);
      check($sformatf("v%0d_valid_end", v), 32'(valid), 32'h0);
      check($sformatf("v%0d_busy_end", v), 32'(busy), 32'h0);
      step_edge();
      check($sformatf("v%0d_done_pulse", v), 32'(done), 32'h0);
    end

    // Backpressure: step 4 with ready pattern 1,0,0,1,0,1,1.
    begin
      logic [6:0]        pat;
      logic [6:0][W-1:0] exp_g;
      pat   = 7'b1101001;
      exp_g = {8'h02, 8'h03, 8'h03, 8'h01, 8'h01, 8'h01, 8'h00};
      ready = 1'b1;
      begin_run(1'b1, 8'h00, 1'b1, 8'd4);
      for (int i = 0; i < 7; i++) begin
        ready = pat[i];
        check($sformatf("bp_valid%0d", i), 32'(valid), 32'h1);
        check($sformatf("bp_code%0d", i), 32'(G_out), 32'(exp_g[i]));
        beat_model(1'b1);
        step_edge();
      end
      check("bp_xfers", 32'(xfers), 32'd4);
      check("bp_done", 32'(done), 32'h1);
      check("bp_valid_end", 32'(valid), 32'h0);
      step_edge();
    end

    // Stop after 4 transfers of a 10-step run, then continue with step 2.
    ready = 1'b1;
    begin_run(1'b1, 8'h00, 1'b1, 8'd10);
    for (int i = 0; i < 4; i++) begin
      beat_model(1'b1);
      step_edge();
    end
    ready = 1'b0;
    stop  = 1'b1;
    check("stop_pre_code", 32'(G_out), 32'h06);
    step_edge();
    stop = 1'b0;
    check("stop_valid", 32'(valid), 32'h0);
    check("stop_busy",  32'(busy),  32'h0);
    check("stop_done",  32'(done),  32'h0);
    step_edge();
    check("stop_done_later", 32'(done), 32'h0);
    ready = 1'b1;
    begin_run(1'b0, 8'h00, 1'b1, 8'd2);
    check("restart_code0", 32'(G_out), 32'h06);
    beat_model(1'b1);
    step_edge();
    check("restart_code1", 32'(G_out), 32'h07);
    beat_model(1'b1);
    step_edge();
    check("restart_done", 32'(done), 32'h1);
    step_edge();

    // step_cnt == 0: immediate done, no beats, counter untouched.
    begin_run(1'b0, 8'h00, 1'b1, 8'd0);
    check("zero_done",  32'(done),  32'h1);
    check("zero_valid", 32'(valid), 32'h0);
    check("zero_busy",  32'(busy),  32'h0);
    step_edge();
    check("zero_done_pulse", 32'(done), 32'h0);
    check("zero_valid2", 32'(valid), 32'h0);
    begin_run(1'b0, 8'h00, 1'b1, 8'd1);
    check("zero_continue", 32'(G_out), 32'h05);
    step_edge();
    check("single_done", 32'(done), 32'h1);
    step_edge();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
